// File: rtl/hazard_sequencer_if.sv
// Control bundle between the hazard sources (IDU/LSU/EXU) and the hazard sequencer.
// The master drives the hazard requests; the slave returns the per-register pipeline controls.
interface hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       idu_stall;
  logic             ldst_stall;
  logic             flush_req;
  logic             timeout_clr;
  logic             stall;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_bubble;
  logic             flush_active;
  logic             stall_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output idu_stall, ldst_stall, flush_req, timeout_clr,
    input  stall, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_bubble, flush_active,
           stall_timeout, stall_cycles
  );

  modport slave (
    input  idu_stall, ldst_stall, flush_req, timeout_clr,
    output stall, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_bubble, flush_active,
           stall_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Per-register pipeline enable/flush/bubble sequencer with multi-cycle and deferred flush,
// a consecutive-stall watchdog and a saturating stall-cycle counter.
module hazard_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_sequencer_if.slave   bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [TC_W-1:0] CONSEC_LAST  = TC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_PEND} state_t;
  typedef enum logic [2:0] {M_RUN, M_MEM, M_FLUSH, M_MD, M_LDUSE} mode_t;

  state_t           fsm;
  mode_t            mode;
  logic [FC_W-1:0]  flush_cnt;
  logic [TC_W-1:0]  consec_cnt;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             stall_timeout_q;

  // A memory wait freezes everything, so it outranks a redirect; the redirect is then deferred.
  always_comb begin
    if (bus.ldst_stall)                                mode = M_MEM;
    else if (bus.flush_req || fsm != S_RUN)            mode = M_FLUSH;
    else if (bus.idu_stall[1])                         mode = M_MD;
    else if (bus.idu_stall[0])                         mode = M_LDUSE;
    else                                               mode = M_RUN;
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.stall         = 1'b0;
    bus.if_id_en      = 1'b1;
    bus.id_ex_en      = 1'b1;
    bus.ex_mem_en     = 1'b1;
    bus.mem_wb_en     = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.ex_mem_bubble = 1'b0;
    bus.flush_active  = 1'b0;
    case (mode)
      M_MEM: begin
        bus.stall     = 1'b1;
        bus.if_id_en  = 1'b0;
        bus.id_ex_en  = 1'b0;
        bus.ex_mem_en = 1'b0;
        bus.mem_wb_en = 1'b0;
      end
      M_FLUSH: begin
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
        bus.flush_active = 1'b1;
      end
      M_MD: begin
        bus.stall         = 1'b1;
        bus.if_id_en      = 1'b0;
        bus.id_ex_en      = 1'b0;
        bus.ex_mem_bubble = 1'b1;
      end
      M_LDUSE: begin
        bus.stall       = 1'b1;
        bus.if_id_en    = 1'b0;
        bus.id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: synchronous reset; state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm             <= S_RUN;
      flush_cnt       <= '0;
      consec_cnt      <= '0;
      stall_cycles_q  <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      case (mode)
        M_MEM: begin
          if (bus.flush_req) fsm <= S_PEND;
        end
        M_FLUSH: begin
          if (bus.flush_req || fsm == S_PEND) begin
            flush_cnt <= FLUSH_RELOAD;
            fsm       <= (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
            if (flush_cnt <= FC_W'(1)) fsm <= S_RUN;
          end
        end
        default: ;
      endcase

      if (!bus.stall)                  consec_cnt <= '0;
      else if (consec_cnt != CONSEC_LAST) consec_cnt <= consec_cnt + TC_W'(1);

      // Setting the watchdog wins over a same-cycle clear.
      if (bus.stall && consec_cnt == CONSEC_LAST) stall_timeout_q <= 1'b1;
      else if (bus.timeout_clr)                   stall_timeout_q <= 1'b0;

      if (bus.stall && stall_cycles_q != {CNT_W{1'b1}})
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles  = stall_cycles_q;
  assign bus.stall_timeout = stall_timeout_q;
endmodule
